// File: rtl/bmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// bmem_responder_pkg
// Shared definitions for the burst-memory responder: burst geometry (beat
// count, beat width, line width), the byte-offset width of a line address,
// and the state type of the read-return engine.
// No ports; imported by bmem_responder.
// ---------------------------------------------------------------------------
package bmem_responder_pkg;

   localparam int BEATS    = 4;
   localparam int BEAT_W   = 64;
   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST
   } state_e;

endpackage

// File: rtl/bmem_req_fifo.sv
// ---------------------------------------------------------------------------
// bmem_req_fifo
// Small synchronous FIFO holding outstanding read-request addresses.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (empties the FIFO)
//   i_push    - write i_data at the tail (ignored when full)
//   i_data    - entry to enqueue
//   i_pop     - drop the head entry (ignored when empty)
//   o_head    - current head entry (stale when empty)
//   o_count   - number of entries held
//   o_empty   - no entries held
//   o_full    - DEPTH entries held
// ---------------------------------------------------------------------------
module bmem_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_pop,
   output logic [WIDTH-1:0]        o_head,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_empty,
   output logic                    o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_slots [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Entry storage carries no reset: an entry is only meaningful once the
   // count says it has been written.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_slots[r_wrPtr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
   // the count unchanged while both pointers advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_slots[r_rdPtr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/bmem_responder.sv
// ---------------------------------------------------------------------------
// bmem_responder
// Behavioural burst-memory responder. Holds DEPTH_LINES lines of 256 bits.
// Writes arrive as 4-beat bursts of 64-bit words; reads are queued and each
// is answered, READ_LATENCY cycles later, with a 4-beat burst of the line.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   bmem_addr    - request address (line index in bits [5 +: log2(DEPTH_LINES)])
//   bmem_read    - read request
//   bmem_write   - write beat valid (held high for all 4 beats)
//   bmem_wdata   - write beat data
//   bmem_ready   - a new request can be accepted this cycle
//   bmem_raddr   - line-aligned address of the burst being returned
//   bmem_rdata   - read beat data
//   bmem_rvalid  - bmem_rdata / bmem_raddr valid
// ---------------------------------------------------------------------------
module bmem_responder
   import bmem_responder_pkg::*;
#(
   parameter int DEPTH_LINES  = 64,
   parameter int READ_LATENCY = 4,
   parameter int QUEUE_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       bmem_addr,
   input  logic              bmem_read,
   input  logic              bmem_write,
   input  logic [BEAT_W-1:0] bmem_wdata,
   output logic              bmem_ready,
   output logic [31:0]       bmem_raddr,
   output logic [BEAT_W-1:0] bmem_rdata,
   output logic              bmem_rvalid
);

   localparam int LIDX_W = $clog2(DEPTH_LINES);
   localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
   // Value of the latency counter on the last WAIT cycle (WAIT lasts
   // READ_LATENCY-1 cycles; with latency 1 the WAIT state is skipped).
   localparam logic [15:0] LAT_LAST = 16'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   logic [BEAT_W-1:0] r_mem [DEPTH_LINES][BEATS];

   logic              r_outOfReset;
   logic [1:0]        r_wrBeat;
   state_e            r_state;
   logic [15:0]       r_latCnt;
   logic [1:0]        r_beatCnt;
   logic              r_rvalid;

   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_wrEn;
   logic              w_moreQueued;
   logic [31:0]       w_alignedAddr;
   logic [31:0]       w_head;
   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic              w_full;
   logic [LIDX_W-1:0] w_wrLine;
   logic [LIDX_W-1:0] w_rdLine;
   logic              w_unusedOffset;

   // Ready is held low for the first cycle after reset, during write beats
   // 1-3, and whenever the queue is full (even if it pops this cycle).
   assign w_ready       = r_outOfReset && (r_wrBeat == 2'd0) && !w_full;
   assign w_push        = bmem_read && w_ready && !bmem_write;
   assign w_wrEn        = (r_wrBeat == 2'd0) ? (bmem_write && w_ready) : bmem_write;
   assign w_pop         = (r_state == ST_BURST) && (r_beatCnt == 2'd3);
   assign w_moreQueued  = (w_count > CNT_W'(1));
   assign w_alignedAddr = {bmem_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   assign w_wrLine      = bmem_addr[OFFSET_W +: LIDX_W];
   assign w_rdLine      = w_head[OFFSET_W +: LIDX_W];
   assign w_unusedOffset = ^bmem_addr[OFFSET_W-1:0];

   bmem_req_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (32)
   ) u_reqFifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_alignedAddr),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // Backing store: deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[w_wrLine][r_wrBeat] <= bmem_wdata;
      end
   end

   // Write-burst beat tracker; the 2-bit counter wraps back to 0 after
   // beat 3, which is what re-opens ready. Beats only advance while
   // bmem_write is high, so a stalled burst simply waits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outOfReset <= 1'b0;
         r_wrBeat     <= 2'd0;
      end else begin
         r_outOfReset <= 1'b1;
         if (w_wrEn) begin
            r_wrBeat <= r_wrBeat + 2'd1;
         end
      end
   end

   // Read-return engine. rvalid is registered alongside the state so it is
   // high exactly while in BURST. Leaving BURST only looks at entries that
   // were already queued behind the head; a request accepted during the
   // last beat goes through IDLE like any request arriving at an idle
   // engine, which keeps its latency identical to the idle case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_latCnt  <= 16'd0;
         r_beatCnt <= 2'd0;
         r_rvalid  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_latCnt  <= 16'd0;
                  r_beatCnt <= 2'd0;
                  if (READ_LATENCY == 1) begin
                     r_state  <= ST_BURST;
                     r_rvalid <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_latCnt == LAT_LAST) begin
                  r_state   <= ST_BURST;
                  r_rvalid  <= 1'b1;
                  r_beatCnt <= 2'd0;
               end else begin
                  r_latCnt <= r_latCnt + 16'd1;
               end
            end
            ST_BURST: begin
               if (r_beatCnt == 2'd3) begin
                  r_beatCnt <= 2'd0;
                  r_latCnt  <= 16'd0;
                  if (w_moreQueued && (READ_LATENCY == 1)) begin
                     r_state  <= ST_BURST;
                     r_rvalid <= 1'b1;
                  end else if (w_moreQueued) begin
                     r_state  <= ST_WAIT;
                     r_rvalid <= 1'b0;
                  end else begin
                     r_state  <= ST_IDLE;
                     r_rvalid <= 1'b0;
                  end
               end else begin
                  r_beatCnt <= r_beatCnt + 2'd1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_rvalid <= 1'b0;
            end
         endcase
      end
   end

   // Beat data is looked up in the store during the beat itself, so any
   // write that finished on an earlier edge is returned. Address and data
   // are forced to zero whenever no beat is being presented.
   assign bmem_ready  = w_ready;
   assign bmem_rvalid = r_rvalid;
   assign bmem_raddr  = r_rvalid ? w_head : 32'd0;
   assign bmem_rdata  = r_rvalid ? r_mem[w_rdLine][r_beatCnt] : '0;

endmodule

// File: tb/tb_bmem_responder.sv
// ---------------------------------------------------------------------------
// tb_bmem_responder
// Directed bench for bmem_responder. A transaction-level model (queue of
// outstanding reads with their scheduled start cycles, plus a word-array
// image of the store) predicts ready/rvalid/raddr/rdata every cycle, and a
// few literal expectations pin the model for the headline scenarios.
// ---------------------------------------------------------------------------
module tb_bmem_responder;

   localparam int DEPTH_LINES  = 64;
   localparam int READ_LATENCY = 4;
   localparam int QUEUE_DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_write;
   logic [63:0] bmem_wdata;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;

   bmem_responder #(
      .DEPTH_LINES  (DEPTH_LINES),
      .READ_LATENCY (READ_LATENCY),
      .QUEUE_DEPTH  (QUEUE_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] addr;
      int          start;
   } req_t;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [63:0] data;
   } beat_t;

   logic [63:0] mdlMem   [DEPTH_LINES][4];
   bit          mdlKnown [DEPTH_LINES][4];
   req_t        mdlQ[$];
   bit          mdlOutOfReset = 1'b0;
   int          mdlWrBeat     = 0;
   int          mdlLastEnd    = -1000;
   bit          readAccepted  = 1'b0;
   bit          writeAccepted = 1'b0;
   int          lastAcceptCyc = 0;
   beat_t       obs[$];

   function automatic int lineOf(input logic [31:0] addr);
      return int'(addr[5 +: 6]);
   endfunction

   function automatic bit mdlReady();
      return mdlOutOfReset && (mdlWrBeat == 0) && (mdlQ.size() < QUEUE_DEPTH);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction model, advanced on every rising edge with the inputs the
   // bench presented during the cycle that edge ends. A read accepted in
   // cycle A starts its burst at A+RL+1, or RL cycles after the previous
   // burst's last beat if that is later; the entry leaves the queue after
   // its fourth beat.
   always @(posedge clk) begin
      bit rdy;
      readAccepted  = 1'b0;
      writeAccepted = 1'b0;
      if (rst) begin
         mdlQ.delete();
         mdlOutOfReset = 1'b0;
         mdlWrBeat     = 0;
         mdlLastEnd    = -1000;
      end else begin
         rdy = mdlReady();
         if (mdlQ.size() > 0 && mdlQ[0].start + 3 == cyc) begin
            void'(mdlQ.pop_front());
         end
         if (mdlWrBeat == 0) begin
            if (bmem_write && rdy) begin
               mdlMem[lineOf(bmem_addr)][0]   = bmem_wdata;
               mdlKnown[lineOf(bmem_addr)][0] = 1'b1;
               mdlWrBeat     = 1;
               writeAccepted = 1'b1;
            end else if (bmem_read && rdy) begin
               req_t r;
               r.addr  = {bmem_addr[31:5], 5'b0};
               r.start = (cyc + READ_LATENCY + 1 > mdlLastEnd + READ_LATENCY) ?
                         cyc + READ_LATENCY + 1 : mdlLastEnd + READ_LATENCY;
               mdlLastEnd = r.start + 3;
               mdlQ.push_back(r);
               readAccepted  = 1'b1;
               lastAcceptCyc = cyc;
            end
         end else if (bmem_write) begin
            mdlMem[lineOf(bmem_addr)][mdlWrBeat]   = bmem_wdata;
            mdlKnown[lineOf(bmem_addr)][mdlWrBeat] = 1'b1;
            mdlWrBeat = (mdlWrBeat + 1) % 4;
         end
         mdlOutOfReset = 1'b1;
      end
      cyc++;
   end

   // Per-cycle comparison on the falling edge, plus a log of every beat the
   // DUT presents for the literal checks in the directed scenarios.
   always @(negedge clk) begin
      logic        expReady;
      logic        expValid;
      logic [31:0] expAddr;
      logic [63:0] expData;
      bit          known;
      int          b;
      expReady = 1'b0;
      expValid = 1'b0;
      expAddr  = 32'd0;
      expData  = 64'd0;
      known    = 1'b0;
      if (!rst) begin
         expReady = mdlReady();
         if (mdlQ.size() > 0 && cyc >= mdlQ[0].start && cyc <= mdlQ[0].start + 3) begin
            expValid = 1'b1;
            expAddr  = mdlQ[0].addr;
            b        = cyc - mdlQ[0].start;
            known    = mdlKnown[lineOf(expAddr)][b];
            expData  = mdlMem[lineOf(expAddr)][b];
         end
      end
      checkOutput("ready", 64'(bmem_ready), 64'(expReady));
      checkOutput("rvalid", 64'(bmem_rvalid), 64'(expValid));
      if (rst) begin
         checkOutput("rstRaddr", 64'(bmem_raddr), 64'd0);
         checkOutput("rstRdata", bmem_rdata, 64'd0);
      end else if (expValid) begin
         checkOutput("raddr", 64'(bmem_raddr), 64'(expAddr));
         if (known) begin
            checkOutput("rdata", bmem_rdata, expData);
         end
      end
      if (bmem_rvalid && !rst) begin
         beat_t o;
         o.cyc  = cyc;
         o.addr = bmem_raddr;
         o.data = bmem_rdata;
         obs.push_back(o);
      end
   end

   task automatic writeLine(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3, input bit alsoRead);
      logic [63:0] d [4];
      int n;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      bmem_addr  = addr;
      bmem_write = 1'b1;
      bmem_read  = alsoRead;
      bmem_wdata = d[0];
      n = 0;
      do begin
         tick();
         n++;
      end while (!writeAccepted && n < 50);
      if (!writeAccepted) begin
         checks++;
         fails++;
         $display("[TB] FAIL writeStart timeout: got no accept, expected accept within 50 cycles");
      end
      bmem_read = 1'b0;
      for (int k = 1; k < 4; k++) begin
         bmem_wdata = d[k];
         tick();
      end
      bmem_write = 1'b0;
   endtask

   task automatic issueRead(input logic [31:0] addr);
      int n;
      bmem_addr  = addr;
      bmem_read  = 1'b1;
      bmem_write = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!readAccepted && n < 50);
      if (!readAccepted) begin
         checks++;
         fails++;
         $display("[TB] FAIL readAccept timeout: got no accept, expected accept within 50 cycles");
      end
      bmem_read = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   // Directed scenario sequence.
   task automatic applyStimulus();
      int acc1;
      int acc5;
      int n;
      logic [31:0] order [5];

      bmem_addr  = 32'd0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = 64'd0;
      rst        = 1'b0;
      #1 rst = 1'b1;
      idle(3);
      checkOutput("resetReadyLow", 64'(bmem_ready), 64'd0);
      checkOutput("resetRvalidLow", 64'(bmem_rvalid), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("readyStillLowAfterRelease", 64'(bmem_ready), 64'd0);
      tick();
      checkOutput("readyAfterReset", 64'(bmem_ready), 64'd1);

      $display("[TB] write line 2 then read it back");
      obs.delete();
      writeLine(32'h40, 64'h11, 64'h22, 64'h33, 64'h44, 1'b0);
      issueRead(32'h40);
      idle(12);
      checkOutput("wrRdBeats", 64'(obs.size()), 64'd4);
      if (obs.size() == 4) begin
         checkOutput("wrRdBeat0", obs[0].data, 64'h11);
         checkOutput("wrRdBeat1", obs[1].data, 64'h22);
         checkOutput("wrRdBeat2", obs[2].data, 64'h33);
         checkOutput("wrRdBeat3", obs[3].data, 64'h44);
         checkOutput("wrRdAddr", 64'(obs[3].addr), 64'h40);
      end

      $display("[TB] 0x800 aliases line 0, single-read latency");
      writeLine(32'h800, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 1'b0);
      obs.delete();
      issueRead(32'h0);
      acc1 = lastAcceptCyc;
      idle(12);
      checkOutput("aliasBeats", 64'(obs.size()), 64'd4);
      if (obs.size() == 4) begin
         checkOutput("aliasData0", obs[0].data, 64'hA0);
         checkOutput("aliasData3", obs[3].data, 64'hA3);
         checkOutput("aliasAddr", 64'(obs[0].addr), 64'h0);
         checkOutput("latFirstBeat", 64'(obs[0].cyc - acc1), 64'd5);
         checkOutput("latLastBeat", 64'(obs[3].cyc - acc1), 64'd8);
      end

      $display("[TB] read+write together at 0x20");
      obs.delete();
      writeLine(32'h20, 64'h55, 64'h66, 64'h77, 64'h88, 1'b1);
      idle(12);
      checkOutput("rdWrNoBurst", 64'(obs.size()), 64'd0);
      issueRead(32'h20);
      idle(12);
      checkOutput("rdWrBeats", 64'(obs.size()), 64'd4);
      if (obs.size() == 4) begin
         checkOutput("rdWrData0", obs[0].data, 64'h55);
         checkOutput("rdWrData3", obs[3].data, 64'h88);
      end

      $display("[TB] write lands while read waits");
      writeLine(32'h60, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 1'b0);
      obs.delete();
      issueRead(32'h60);
      writeLine(32'h60, 64'hC0, 64'hC1, 64'hC2, 64'hC3, 1'b0);
      idle(12);
      checkOutput("lateWrBeats", 64'(obs.size()), 64'd4);
      if (obs.size() == 4) begin
         checkOutput("lateWrData0", obs[0].data, 64'hC0);
         checkOutput("lateWrData3", obs[3].data, 64'hC3);
      end

      $display("[TB] five back-to-back reads");
      writeLine(32'h80, 64'hD0, 64'hD1, 64'hD2, 64'hD3, 1'b0);
      obs.delete();
      order[0] = 32'h40; order[1] = 32'h20; order[2] = 32'h60; order[3] = 32'h80; order[4] = 32'h0;
      issueRead(32'h5F);
      acc1 = lastAcceptCyc;
      issueRead(32'h20);
      issueRead(32'h60);
      issueRead(32'h80);
      checkOutput("readyLowWhenFull", 64'(bmem_ready), 64'd0);
      issueRead(32'h0);
      acc5 = lastAcceptCyc;
      checkOutput("fifthAcceptAfterPop", 64'(acc5 - acc1), 64'd9);
      idle(40);
      checkOutput("fiveReadBeats", 64'(obs.size()), 64'd20);
      if (obs.size() == 20) begin
         for (int i = 0; i < 20; i++) begin
            checkOutput("fiveReadOrder", 64'(obs[i].addr), 64'(order[i / 4]));
         end
         checkOutput("fiveReadData0", obs[0].data, 64'h11);
         checkOutput("fiveReadData19", obs[19].data, 64'hA3);
         checkOutput("fiveReadNoGap", 64'(obs[3].cyc - obs[0].cyc), 64'd3);
      end

      $display("[TB] reset during burst beat 1");
      issueRead(32'h40);
      n = 0;
      while (!bmem_rvalid && n < 30) begin
         tick();
         n++;
      end
      if (!bmem_rvalid) begin
         checks++;
         fails++;
         $display("[TB] FAIL burstStart timeout: got no rvalid, expected rvalid within 30 cycles");
      end
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rstMidBurstRvalid", 64'(bmem_rvalid), 64'd0);
      checkOutput("rstMidBurstRdata", bmem_rdata, 64'd0);
      idle(2);
      rst = 1'b0;
      obs.delete();
      idle(15);
      checkOutput("noResidualBeats", 64'(obs.size()), 64'd0);
      checkOutput("readyAfterMidReset", 64'(bmem_ready), 64'd1);
   endtask

   initial begin
      applyStimulus();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Last-resort guard so the run always ends with a summary.
   initial begin
      #100000;
      checks++;
      fails++;
      $display("[TB] FAIL watchdog: got no completion, expected completion before 100000 ns");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
